// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with enable prescaler, synchronous load and terminal-count pulse.
// Define CONTADOR_BCD_SAT_EN to saturate at 99/00 instead of wrapping.
module contador_bcd #(
   parameter int unsigned DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [7:0] din,
   output logic [3:0] bcd_uni,
   output logic [3:0] bcd_dez,
   output logic       tc,
   output logic       err
);

   localparam int unsigned    PW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PS_MAX = PW'(DIV - 1);

   logic [PW-1:0] ps;
   logic          step;
   logic          din_ok;
   logic [3:0]    uni_nx, dez_nx;
   logic          wrap;

   assign step   = en && !load && (ps == PS_MAX);
   assign din_ok = (din[7:4] <= 4'd9) && (din[3:0] <= 4'd9);

   // Load clears the prescaler so a fresh count phase starts after every load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps <= '0;
      end else if (load) begin
         ps <= '0;
      end else if (en) begin
         ps <= step ? '0 : ps + 1'b1;
      end
   end

   // Next digits for one step in the sampled direction; wrap flags 99->00 or 00->99.
   always_comb begin
      uni_nx = bcd_uni;
      dez_nx = bcd_dez;
      wrap   = 1'b0;
      if (up) begin
         if (bcd_uni == 4'd9) begin
            uni_nx = 4'd0;
            if (bcd_dez == 4'd9) begin
               dez_nx = 4'd0;
               wrap   = 1'b1;
            end else begin
               dez_nx = bcd_dez + 4'd1;
            end
         end else begin
            uni_nx = bcd_uni + 4'd1;
         end
      end else begin
         if (bcd_uni == 4'd0) begin
            uni_nx = 4'd9;
            if (bcd_dez == 4'd0) begin
               dez_nx = 4'd9;
               wrap   = 1'b1;
            end else begin
               dez_nx = bcd_dez - 4'd1;
            end
         end else begin
            uni_nx = bcd_uni - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_uni <= 4'd0;
         bcd_dez <= 4'd0;
         tc      <= 1'b0;
         err     <= 1'b0;
      end else begin
         tc  <= 1'b0;
         err <= 1'b0;
         if (load) begin
            if (din_ok) begin
               bcd_dez <= din[7:4];
               bcd_uni <= din[3:0];
            end else begin
               err <= 1'b1;
            end
         end else if (step) begin
            tc <= wrap;
`ifdef CONTADOR_BCD_SAT_EN
            if (!wrap) begin
               bcd_uni <= uni_nx;
               bcd_dez <= dez_nx;
            end
`else
            bcd_uni <= uni_nx;
            bcd_dez <= dez_nx;
`endif
         end
      end
   end

endmodule

// File: doc/contador_bcd.md
CONTADOR_BCD -- requirements
Module: contador_bcd

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning enabled clock cycles per count step (range 1..65535).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  count enable; the prescaler advances only while high.
REQ-005 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port din  input  8  load value, {tens[7:4], units[3:0]}, BCD.
REQ-008 SHALL have port bcd_uni  output  4  units digit, 0..9, drives the 7-segment encoder bcd input.
REQ-009 SHALL have port bcd_dez  output  4  tens digit, 0..9, drives a second encoder instance.
REQ-010 SHALL have port tc  output  1  terminal-count pulse.
REQ-011 SHALL have port err  output  1  invalid-load pulse.

Function
REQ-012 SHALL keep all outputs registered; any change appears one clk edge after the causing input is sampled.
REQ-013 SHALL hold an internal prescaler 0..DIV-1; it increments on each edge with en=1 and load=0, and holds with en=0.
REQ-014 SHALL generate a count step when en=1, load=0 and the prescaler equals DIV-1; the prescaler returns to 0 on that step.
REQ-015 SHALL, with DIV=1, step on every edge where en=1 and load=0.
REQ-016 SHALL give load priority over counting; on a load edge the prescaler clears to 0 and no step occurs.
REQ-017 SHALL, on a load where din[7:4]<=9 and din[3:0]<=9, set bcd_dez/bcd_uni to din at that edge, with err=0.
REQ-018 SHALL, on a load where either din nibble is >9, leave the digits unchanged and assert err for exactly one cycle.
REQ-019 SHALL, on an up step, increment units; units 9 goes to 0 with a tens increment; 99 wraps to 00.
REQ-020 SHALL, on a down step, decrement units; units 0 goes to 9 with a tens decrement; 00 wraps to 99.
REQ-021 SHALL assert tc for exactly one cycle following an up step taken from 99 or a down step taken from 00; otherwise tc=0.
REQ-022 SHALL sample up only at the step edge; a direction change between steps affects the next step only.
REQ-023 SHALL never present a digit value >9 on bcd_uni or bcd_dez.

Reset
REQ-024 SHALL, while rst_n=0, force bcd_uni=0, bcd_dez=0, tc=0, err=0 and prescaler=0, independent of clk.
REQ-025 SHALL, when rst_n deasserts mid-count, restart the prescaler at 0; the first step requires a full DIV enabled cycles after release.
REQ-026 SHALL ignore load and en on any edge where rst_n=0.

Configuration
REQ-027 SHALL, with macro CONTADOR_BCD_SAT_EN defined, saturate instead of wrapping: an up step at 99 holds 99 and a down step at 00 holds 00; tc still pulses per REQ-021.
REQ-028 SHALL, without CONTADOR_BCD_SAT_EN, wrap per REQ-019/REQ-020.

Verification
REQ-029 SHALL cover: DIV=1, reset, en=1, up=1 for 100 cycles -> digits step 00..99 then 00; tc=1 only in the cycle after the 99->00 edge.
REQ-030 SHALL cover: load din=8'h05, then up=0 for 6 steps -> 04,03,02,01,00,99; tc pulses once after the 00->99 edge.
REQ-031 SHALL cover: digits=8'h42, load din=8'h3A -> digits stay 42, err=1 for one cycle; then load 8'h37 -> digits 37, err=0.
REQ-032 SHALL cover: DIV=4, en toggled 1,1,0,1,1 -> one step after the fourth enabled cycle only; the prescaler holds across the en=0 cycle.
REQ-033 SHALL cover: count at 57, rst_n pulsed low between edges -> outputs 00 immediately; after release, the first step comes DIV enabled cycles later.
REQ-034 SHALL cover, with CONTADOR_BCD_SAT_EN: load 8'h98, up=1 for 3 steps -> 99,99,99 with tc pulsing once per step taken at 99; down from 00 holds 00.
